cpu_player: RTL and testbench
=============================

Name: cpu_player

Overview:
Computer opponent for the tug-of-war game. It generates single-cycle "press" pulses in the same form a conditioned player button produces: one cycle high per press. Its output feeds the light chain's L or R input in place of a human button. Press decisions are pseudo-random: on each slow tick, a 10-bit LFSR is compared against a difficulty level taken from the switches. A mandatory cooldown follows every press, and the block stops pressing once the game is won.

Parameters:
TICK_BITS, 20, width of free-running tick divider; tick period = 2^TICK_BITS clocks (about 48 Hz at 50 MHz)
COOL_TICKS, 2, ticks of enforced idle after each press; legal range >= 1
LFSR_W, 10, LFSR width; fixed at 10 for this release

Ports:
Clock      in   1   system clock (CLOCK_50)
Reset      in   1   asynchronous, active-low reset
enable     in   1   computer player active (switch)
level      in   10  difficulty; higher means more frequent presses
game_over  in   1   high while a winner is displayed
press      out  1   one-cycle press pulse, active-high, drop-in for button set output
lfsr_out   out  10  current LFSR value (debug/visibility)

Behaviour:
- Reset low, asynchronous, takes effect immediately:
  - state = IDLE, press = 0, tick counter = 0, LFSR = 0, cooldown = 0.
- Tick counter:
  - Free-running, TICK_BITS wide, increments every clock.
  - tick = 1 in the cycle when the counter is all-ones; the counter then wraps to 0.
- LFSR:
  - Advances only on tick: next = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])} (XNOR, taps 10/7).
  - From 0 the sequence is 0x000, 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE, ...
  - 0x3FF is the lock-up state and is never reached.
- Press condition: on a tick in ARMED, fire when (lfsr < level), unsigned, using the pre-advance LFSR value.
  - level = 0 never fires.
  - level = 0x3FF fires on every eligible tick.
- FSM states: IDLE, ARMED, FIRE, COOL, HALT. game_over has highest priority.
  - any state, game_over = 1 -> HALT.
  - IDLE: enable -> ARMED; else stay.
  - ARMED: ~enable -> IDLE; tick & fire condition -> FIRE; else stay.
  - FIRE: always -> COOL next cycle; cooldown loaded with COOL_TICKS. A pulse is never truncated by enable.
  - COOL: ~enable -> IDLE. On tick: cooldown == 1 -> ARMED, else decrement.
  - HALT: game_over = 0 -> IDLE.
- Output:
  - press = (state == FIRE), Moore and registered. It is high for exactly one cycle, the cycle after the deciding tick.
  - Latency from deciding tick to press is 1 clock.
- Minimum press spacing: (COOL_TICKS + 1) * 2^TICK_BITS clocks.
- Simultaneous events:
  - game_over together with a firing tick -> HALT, no press.
  - ~enable together with a firing tick in ARMED -> IDLE, no press.

Decomposition:
- Shared package tow_pkg:
  - cpu_state_t enum (IDLE, ARMED, FIRE, COOL, HALT)
  - LFSR_W localparam
  - LFSR tap positions
  - LFSR_RESET value 0
- One natural sub-module: tow_lfsr.
  - Function: 10-bit XNOR LFSR with advance enable and async active-low reset.
  - Reusable by a later random-speed feature.
- The tick divider and FSM stay in cpu_player.

Test Plan:
(Bench overrides TICK_BITS = 2, so a tick occurs every 4 clocks; COOL_TICKS = 2.)
1. Reset low, then high; enable = 1, level = 0 for 400 clocks -> press never asserted; lfsr_out steps 0x000, 0x001, 0x003, 0x007 on successive ticks.
2. level = 0x3FF, enable = 1 -> first press 1 clock after the first tick in ARMED, exactly 1 cycle wide; later presses every 12 clocks.
3. level = 0x3FF, assert game_over while in COOL -> HALT next cycle, no press for 100 clocks; deassert -> IDLE, ARMED, then a press on the next tick.
4. game_over and a firing tick in the same cycle -> no press; state = HALT.
5. Drive Reset low asynchronously mid-cycle while press = 1 -> press falls before the next clock edge; lfsr_out = 0; after release the sequence restarts from 0x001.
6. enable dropped during COOL -> IDLE next cycle; re-enable -> ARMED with no stale cooldown, and the next eligible tick can fire.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war computer opponent.
//   cpu_state_t : opponent FSM states
//   LFSR_*      : width, tap positions and reset value of the XNOR LFSR
//   lfsr_next() : one LFSR step, shared by the RTL LFSR and any later user
package tow_pkg;

  localparam int LFSR_W      = 10;
  // Taps 10 and 7 in 1-based polynomial terms, i.e. bits 9 and 6.
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;
  // All-zeros is a legal state for an XNOR LFSR; all-ones is the lock-up state.
  localparam logic [LFSR_W-1:0] LFSR_RESET = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    FIRE  = 3'd2,
    COOL  = 3'd3,
    HALT  = 3'd4
  } cpu_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ~(cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO])};
  endfunction

endpackage

// File: rtl/tow_lfsr.sv
// 10-bit XNOR LFSR (taps 10/7) that steps only when 'advance' is high.
// Ports:
//   Clock   in  system clock
//   Reset   in  asynchronous active-low reset, loads LFSR_RESET
//   advance in  step the register this cycle
//   value   out current register contents
module tow_lfsr
  import tow_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lfsr_q <= LFSR_RESET;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war. Emits one-cycle press pulses, shaped like
// a conditioned button, decided on each slow tick by comparing an LFSR with
// the difficulty level. Each press is followed by a cooldown, and pressing
// stops while a winner is shown.
// Ports:
//   Clock     in   system clock
//   Reset     in   asynchronous active-low reset
//   enable    in   computer player active
//   level     in   difficulty, higher fires more often (0 never, 0x3FF always)
//   game_over in   high while a winner is displayed
//   press     out  one-cycle press pulse
//   lfsr_out  out  current LFSR value (debug)
module cpu_player
  import tow_pkg::*;
#(
  parameter int TICK_BITS  = 20,
  parameter int COOL_TICKS = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] level,
  input  logic              game_over,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_out
);

  localparam int COOL_W = $clog2(COOL_TICKS + 1);

  cpu_state_t        state_q, state_d;
  logic [TICK_BITS-1:0] tick_cnt_q;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              tick;
  logic              fire_hit;
  logic [LFSR_W-1:0] lfsr_val;

  // Tick is the all-ones cycle of the divider; the counter wraps right after.
  assign tick = &tick_cnt_q;

  // Uses the pre-advance value: the LFSR only steps on the same edge.
  assign fire_hit = tick && (lfsr_val < level);

  tow_lfsr u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (tick),
    .value   (lfsr_val)
  );

  // State register, tick divider and cooldown counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      cool_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_q + TICK_BITS'(1);
      cool_q     <= cool_d;
    end
  end

  // Next-state logic. game_over overrides everything, including a firing tick.
  always_comb begin
    // NOTE: default assignment first, so no path through this block leaves
    // state_d unassigned and no latch is inferred.
    state_d = state_q;
    if (game_over) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        IDLE:    if (enable) state_d = ARMED;
        ARMED: begin
          if (!enable)       state_d = IDLE;
          else if (fire_hit) state_d = FIRE;
        end
        // A pulse always completes; enable is not looked at here.
        FIRE:    state_d = COOL;
        COOL: begin
          if (!enable)                              state_d = IDLE;
          else if (tick && cool_q == COOL_W'(1))    state_d = ARMED;
        end
        HALT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Cooldown is loaded while pulsing and counts ticks only while cooling;
  // anywhere else it is cleared so re-arming never sees a stale count.
  always_comb begin
    cool_d = '0;
    if (state_q == FIRE) begin
      cool_d = COOL_W'(COOL_TICKS);
    end else if (state_q == COOL) begin
      cool_d = (tick && cool_q != COOL_W'(1)) ? cool_q - COOL_W'(1) : cool_q;
    end
  end

  // Moore output straight from the state register.
  always_comb begin
    press = (state_q == FIRE);
  end

  assign lfsr_out = lfsr_val;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player with a 4-clock tick and a 2-tick cooldown.
module tb_cpu_player;

  localparam int TB_TICK_BITS = 2;
  localparam int TB_COOL      = 2;
  localparam int TICK_PERIOD  = 1 << TB_TICK_BITS;

  logic       Clock;
  logic       Reset;
  logic       enable;
  logic [9:0] level;
  logic       game_over;
  logic       press;
  logic [9:0] lfsr_out;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_on = 0;

  cpu_player #(
    .TICK_BITS  (TB_TICK_BITS),
    .COOL_TICKS (TB_COOL)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .enable    (enable),
    .level     (level),
    .game_over (game_over),
    .press     (press),
    .lfsr_out  (lfsr_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the opponent is either off, halted, waiting out some
  // number of ticks of cooldown, ready to fire, or showing its pulse.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int         cnt;        // clocks since last wrap of the divider
    logic [9:0] lfsr;
    bit         halted;
    bit         on;         // opponent engaged (ready or cooling)
    bit         pulse;      // press visible this cycle
    int         wait_ticks; // ticks still to sit out; 0 = ready to fire
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, bit en, bit go, logic [9:0] lvl);
    model_t nxt;
    bit     tick_now;
    nxt      = cur;
    tick_now = (cur.cnt == TICK_PERIOD - 1);
    nxt.cnt  = (cur.cnt + 1) % TICK_PERIOD;
    if (tick_now) nxt.lfsr = {cur.lfsr[8:0], ~(cur.lfsr[9] ^ cur.lfsr[6])};
    nxt.pulse = 1'b0;
    if (go) begin
      nxt.halted = 1'b1;
      nxt.on     = 1'b0;
    end else if (cur.halted) begin
      nxt.halted = 1'b0;
    end else if (cur.pulse) begin
      nxt.on         = 1'b1;
      nxt.wait_ticks = TB_COOL;
    end else if (!cur.on) begin
      nxt.on         = en;
      nxt.wait_ticks = 0;
    end else if (!en) begin
      nxt.on = 1'b0;
    end else if (cur.wait_ticks == 0) begin
      if (tick_now && int'(cur.lfsr) < int'(lvl)) begin
        nxt.pulse = 1'b1;
        nxt.on    = 1'b0;
      end
    end else if (tick_now) begin
      nxt.wait_ticks = cur.wait_ticks - 1;
    end
    return nxt;
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) m <= '0;
    else        m <= model_step(m, enable, game_over, level);
  end

  // One compare process, away from the active edge.
  always @(negedge Clock) begin
    if (cmp_on) begin
      check("model_press", {31'd0, press}, {31'd0, m.pulse});
      check("model_lfsr", {22'd0, lfsr_out}, {22'd0, m.lfsr});
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  // Waits up to 'budget' negedges for press; n is how many negedges it took.
  task automatic wait_press(input int budget, output bit found, output int n);
    found = 1'b0;
    n     = 0;
    while (!found && n < budget) begin
      @(negedge Clock);
      n++;
      if (press === 1'b1) found = 1'b1;
    end
  endtask

  logic [9:0] seq_exp [9];
  logic [9:0] seq_seen [$];
  logic [9:0] prev_lfsr;
  bit         any_press;
  bit         found;
  int         n;
  bit         armed_tick;

  initial begin
    Reset     = 1'b0;
    enable    = 1'b0;
    level     = '0;
    game_over = 1'b0;
    seq_exp   = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                  10'h01F, 10'h03F, 10'h07F, 10'h0FE};

    // Reset state.
    @(negedge Clock);
    cmp_on = 1'b1;
    check("reset_press", {31'd0, press}, 32'd0);
    check("reset_lfsr", {22'd0, lfsr_out}, 32'd0);

    // 1: level 0 never fires; LFSR walks the known sequence.
    enable = 1'b1;
    level  = 10'h000;
    Reset  = 1'b1;
    any_press = 1'b0;
    prev_lfsr = lfsr_out;
    seq_seen.push_back(lfsr_out);
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (press === 1'b1) any_press = 1'b1;
      if (lfsr_out !== prev_lfsr) begin
        seq_seen.push_back(lfsr_out);
        prev_lfsr = lfsr_out;
      end
    end
    check("lvl0_no_press", {31'd0, any_press}, 32'd0);
    for (int i = 0; i < 9; i++)
      check("lfsr_seq", {22'd0, seq_seen[i]}, {22'd0, seq_exp[i]});

    // 2: level 0x3FF from a fresh reset: IDLE, ARMED, tick on 4th edge, pulse.
    level = 10'h3FF;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      check("first_press_early", {31'd0, press}, 32'd0);
    end
    @(negedge Clock);
    check("first_press_at4", {31'd0, press}, 32'd1);
    @(negedge Clock);
    check("press_one_wide", {31'd0, press}, 32'd0);
    wait_press(40, found, n);
    check("press_spacing_found", {31'd0, found}, 32'd1);
    check("press_spacing", n + 1, (TB_COOL + 1) * TICK_PERIOD);

    // 3: game_over during cooldown halts; release resumes.
    wait_press(40, found, n);
    check("t3_press_found", {31'd0, found}, 32'd1);
    @(negedge Clock);
    game_over = 1'b1;
    any_press = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (press === 1'b1) any_press = 1'b1;
    end
    check("halt_no_press", {31'd0, any_press}, 32'd0);
    game_over = 1'b0;
    wait_press(8, found, n);
    check("resume_press", {31'd0, found}, 32'd1);

    // 4: game_over on a firing tick suppresses the press.
    armed_tick = 1'b0;
    n = 0;
    while (!armed_tick && n < 60) begin
      @(negedge Clock);
      n++;
      if (m.on && m.wait_ticks == 0 && !m.pulse && !m.halted && m.cnt == TICK_PERIOD - 1)
        armed_tick = 1'b1;
    end
    check("t4_found_tick", {31'd0, armed_tick}, 32'd1);
    game_over = 1'b1;
    @(negedge Clock);
    check("t4_no_press", {31'd0, press}, 32'd0);
    repeat (8) begin
      @(negedge Clock);
      check("t4_halt_hold", {31'd0, press}, 32'd0);
    end
    game_over = 1'b0;

    // 5: asynchronous reset mid-cycle while pressing.
    wait_press(40, found, n);
    check("t5_press_found", {31'd0, found}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("async_press_low", {31'd0, press}, 32'd0);
    check("async_lfsr_zero", {22'd0, lfsr_out}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 10) begin
      @(negedge Clock);
      n++;
      if (lfsr_out !== 10'h000) found = 1'b1;
    end
    check("restart_lfsr", {22'd0, lfsr_out}, 32'h001);

    // 6: enable dropped in cooldown, then re-enabled: fires on next tick.
    wait_press(40, found, n);
    check("t6_press_found", {31'd0, found}, 32'd1);
    @(negedge Clock);
    enable = 1'b0;
    @(negedge Clock);
    check("t6_idle_no_press", {31'd0, press}, 32'd0);
    enable = 1'b1;
    wait_press(6, found, n);
    check("t6_rearm_press", {31'd0, found}, 32'd1);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (game_over) begin
        if ($urandom_range(0, 7) == 0) game_over = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        game_over = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       level = 10'h000;
          1:       level = 10'h3FF;
          default: level = 10'($urandom_range(0, 1023));
        endcase
      end
    end

    @(negedge Clock);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
